// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-stage types and constants
package cpu_pkg;
    typedef enum logic [2:0] {BOOT, RUN, STALL, FLUSH, HALT} state_t;
    localparam logic [5:0]  HALT_OPCODE      = 6'h3F;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control decode, operand and instruction-memory bundle around the fetch stage
interface fetch_unit_if;
    logic        stall;
    logic        jump, jump_reg, branch, branch_ne, branch_gt, branch_gte;
    logic        branch_lt, branch_lte, branch_gt_u, branch_lte_u;
    logic [31:0] rs_val, rt_val;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_out, pc_plus4;
    logic        halt;
    modport slave (
        input  stall, jump, jump_reg, branch, branch_ne, branch_gt, branch_gte,
               branch_lt, branch_lte, branch_gt_u, branch_lte_u, rs_val, rt_val, imem_rdata,
        output imem_addr, instr, instr_valid, pc_out, pc_plus4, halt
    );
    modport master (
        output stall, jump, jump_reg, branch, branch_ne, branch_gt, branch_gte,
               branch_lt, branch_lte, branch_gt_u, branch_lte_u, rs_val, rt_val, imem_rdata,
        input  imem_addr, instr, instr_valid, pc_out, pc_plus4, halt
    );
endinterface

// File: rtl/branch_compare.sv
// branch_compare: combinational branch-taken decision from operands and branch kind
module branch_compare (
    input  logic [31:0] i_rs,
    input  logic [31:0] i_rt,
    input  logic        i_branch,
    input  logic        i_branch_ne,
    input  logic        i_branch_gt,
    input  logic        i_branch_gte,
    input  logic        i_branch_lt,
    input  logic        i_branch_lte,
    input  logic        i_branch_gt_u,
    input  logic        i_branch_lte_u,
    output logic        o_taken
);
    logic w_eq, w_lt_s, w_lt_u;
    assign w_eq   = i_rs == i_rt;
    assign w_lt_s = $signed(i_rs) < $signed(i_rt);
    assign w_lt_u = i_rs < i_rt;
    assign o_taken = (i_branch & w_eq) | (i_branch_ne & ~w_eq)
                   | (i_branch_gt & ~w_lt_s & ~w_eq) | (i_branch_gte & ~w_lt_s)
                   | (i_branch_lt & w_lt_s) | (i_branch_lte & (w_lt_s | w_eq))
                   | (i_branch_gt_u & ~w_lt_u & ~w_eq) | (i_branch_lte_u & (w_lt_u | w_eq));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, redirect and stall handling in front of a synchronous instruction memory
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.slave fu
);
    state_t      r_state;
    logic [31:0] r_fpc, r_dpc, r_hold;
    logic [31:0] w_instr, w_pc4, w_br_tgt, w_target;
    logic        w_valid, w_taken, w_redirect, w_halt_instr;
    assign w_instr      = r_state == RUN ? fu.imem_rdata : r_state == STALL ? r_hold : '0;
    assign w_valid      = r_state == RUN || r_state == STALL;
    assign w_pc4        = r_dpc + 32'd4;
    assign w_br_tgt     = w_pc4 + {{14{w_instr[15]}}, w_instr[15:0], 2'b00};
    assign w_target     = fu.jump_reg ? fu.rs_val
                        : fu.jump ? {w_pc4[31:28], w_instr[25:0], 2'b00} : w_br_tgt;
    assign w_redirect   = fu.jump_reg | fu.jump | w_taken;
    assign w_halt_instr = w_valid && w_instr[31:26] == HALT_OPCODE;
    branch_compare u_cmp (
        .i_rs(fu.rs_val), .i_rt(fu.rt_val),
        .i_branch(fu.branch), .i_branch_ne(fu.branch_ne),
        .i_branch_gt(fu.branch_gt), .i_branch_gte(fu.branch_gte),
        .i_branch_lt(fu.branch_lt), .i_branch_lte(fu.branch_lte),
        .i_branch_gt_u(fu.branch_gt_u), .i_branch_lte_u(fu.branch_lte_u),
        .o_taken(w_taken)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BOOT;
            r_fpc   <= RESET_PC;
            r_dpc   <= RESET_PC;
            r_hold  <= '0;
        end else begin
            case (r_state)
                BOOT, FLUSH: begin
                    r_fpc   <= r_fpc + 32'd4;
                    r_dpc   <= r_fpc;
                    r_state <= RUN;
                end
                RUN, STALL: begin
                    if (w_halt_instr) r_state <= HALT;
                    else if (fu.stall) begin
                        // memory has already moved past the stalled word, so keep a copy
                        if (r_state == RUN) r_hold <= fu.imem_rdata;
                        r_state <= STALL;
                    end else begin
                        r_dpc   <= r_fpc;
                        r_fpc   <= w_redirect ? w_target : r_fpc + 32'd4;
                        r_state <= w_redirect ? FLUSH : RUN;
                    end
                end
                HALT: r_state <= HALT;
                default: r_state <= BOOT;
            endcase
        end
    end
    assign fu.imem_addr   = rst ? RESET_PC : r_fpc;
    assign fu.instr       = w_instr;
    assign fu.instr_valid = w_valid;
    assign fu.pc_out      = r_dpc;
    assign fu.pc_plus4    = w_pc4;
    assign fu.halt        = r_state == HALT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of sequencing, redirects, stall, halt and reset
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem [256];
    logic        force_j = 1'b0;
    int          n_vec = 0;
    int          n_err = 0;
    fetch_unit_if bus ();
    fetch_unit #(.RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .fu(bus));
    always #5 clk = ~clk;
    always @(posedge clk) bus.imem_rdata <= mem[bus.imem_addr[9:2]];
    logic [5:0] op, fn;
    always_comb begin
        op = bus.instr[31:26];
        fn = bus.instr[5:0];
        bus.jump_reg     = op == 6'h00 && fn == 6'h08;
        bus.jump         = op == 6'h02 || (bus.jump_reg && force_j);
        bus.branch       = op == 6'h04;
        bus.branch_ne    = op == 6'h05;
        bus.branch_gt    = op == 6'h07;
        bus.branch_gt_u  = op == 6'h0B;
        bus.branch_gte   = 1'b0;
        bus.branch_lt    = 1'b0;
        bus.branch_lte   = 1'b0;
        bus.branch_lte_u = 1'b0;
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic clr();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask
    task automatic boot();
        rst = 1'b1;
        tick(2);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_halt", {31'h0, bus.halt}, 32'h0);
        rst = 1'b0;
        chk("boot_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("boot_instr", bus.instr, 32'h0);
    endtask
    initial begin
        bus.stall = 1'b0;
        bus.rs_val = 32'h0;
        bus.rt_val = 32'h0;
        clr();
        boot();
        tick(1);
        chk("seq0_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("seq0_pc", bus.pc_out, 32'h0);
        chk("seq0_addr", bus.imem_addr, 32'h4);
        tick(1);
        chk("seq1_pc", bus.pc_out, 32'h4);
        chk("seq1_addr", bus.imem_addr, 32'h8);
        tick(1);
        chk("seq2_pc", bus.pc_out, 32'h8);
        chk("seq2_addr", bus.imem_addr, 32'hC);
        chk("seq2_pc4", bus.pc_plus4, 32'hC);
        mem[4] = 32'h1022_0003;
        mem[8] = 32'h2108_0020;
        bus.rs_val = 32'd5;
        bus.rt_val = 32'd5;
        boot();
        tick(5);
        chk("beq_pc", bus.pc_out, 32'h10);
        chk("beq_instr", bus.instr, 32'h1022_0003);
        tick(1);
        chk("beq_bubble", {31'h0, bus.instr_valid}, 32'h0);
        chk("beq_addr", bus.imem_addr, 32'h20);
        tick(1);
        chk("beq_tgt_pc", bus.pc_out, 32'h20);
        chk("beq_tgt_instr", bus.instr, 32'h2108_0020);
        bus.rt_val = 32'd6;
        boot();
        tick(6);
        chk("beq_nt_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("beq_nt_pc", bus.pc_out, 32'h14);
        clr();
        mem[4] = 32'h1C22_0003;
        mem[5] = 32'h2C22_0003;
        mem[9] = 32'h2108_0020;
        bus.rs_val = 32'hFFFF_FFFF;
        bus.rt_val = 32'h1;
        boot();
        tick(6);
        chk("bgt_nt_valid", {31'h0, bus.instr_valid}, 32'h1);
        chk("bgt_nt_pc", bus.pc_out, 32'h14);
        tick(1);
        chk("bgtu_bubble", {31'h0, bus.instr_valid}, 32'h0);
        tick(1);
        chk("bgtu_pc", bus.pc_out, 32'h24);
        chk("bgtu_instr", bus.instr, 32'h2108_0020);
        clr();
        mem[16]  = 32'h0020_0008;
        mem[64]  = 32'h0800_0080;
        mem[128] = 32'h2108_0020;
        force_j = 1'b1;
        bus.rs_val = 32'h100;
        boot();
        tick(17);
        chk("jr_pc", bus.pc_out, 32'h40);
        tick(1);
        chk("jr_bubble", {31'h0, bus.instr_valid}, 32'h0);
        chk("jr_addr", bus.imem_addr, 32'h100);
        tick(1);
        chk("j_pc", bus.pc_out, 32'h100);
        tick(1);
        chk("j_addr", bus.imem_addr, 32'h200);
        tick(1);
        chk("j_tgt_pc", bus.pc_out, 32'h200);
        chk("j_tgt_instr", bus.instr, 32'h2108_0020);
        force_j = 1'b0;
        clr();
        mem[2] = 32'h8C22_0000;
        mem[3] = 32'h2003_000C;
        mem[4] = 32'h2004_0010;
        mem[5] = 32'hFC00_0000;
        boot();
        tick(3);
        chk("lw_pc", bus.pc_out, 32'h8);
        bus.stall = 1'b1;
        tick(1);
        chk("stall1_instr", bus.instr, 32'h8C22_0000);
        chk("stall1_addr", bus.imem_addr, 32'hC);
        tick(2);
        chk("stall3_pc", bus.pc_out, 32'h8);
        chk("stall3_instr", bus.instr, 32'h8C22_0000);
        chk("stall3_valid", {31'h0, bus.instr_valid}, 32'h1);
        bus.stall = 1'b0;
        tick(1);
        chk("rel_pc", bus.pc_out, 32'hC);
        chk("rel_instr", bus.instr, 32'h2003_000C);
        tick(1);
        chk("rel2_pc", bus.pc_out, 32'h10);
        chk("rel2_instr", bus.instr, 32'h2004_0010);
        tick(1);
        chk("halt_instr_pc", bus.pc_out, 32'h14);
        tick(1);
        chk("halt_flag", {31'h0, bus.halt}, 32'h1);
        chk("halt_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("halt_addr", bus.imem_addr, 32'h18);
        tick(2);
        chk("halt_hold_addr", bus.imem_addr, 32'h18);
        chk("halt_hold_pc", bus.pc_out, 32'h14);
        rst = 1'b1;
        tick(1);
        chk("halt_rst_flag", {31'h0, bus.halt}, 32'h0);
        chk("halt_rst_addr", bus.imem_addr, 32'h0);
        rst = 1'b0;
        tick(1);
        chk("after_halt_pc", bus.pc_out, 32'h0);
        chk("after_halt_valid", {31'h0, bus.instr_valid}, 32'h1);
        tick(2);
        bus.stall = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("stall_rst_valid", {31'h0, bus.instr_valid}, 32'h0);
        chk("stall_rst_pc", bus.pc_out, 32'h0);
        rst = 1'b0;
        bus.stall = 1'b0;
        tick(2);
        chk("stall_rst_seq_pc", bus.pc_out, 32'h4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port stall  in  1  hold the decode instruction and the PC.
REQ-005 SHALL have ports jump, jump_reg, branch, branch_ne, branch_gt, branch_gte, branch_lt, branch_lte, branch_gt_u, branch_lte_u  in  1 each  control-unit decode of the current instr.
REQ-006 SHALL have ports rs_val, rt_val  in  32  register-file operands of the current instr.
REQ-007 SHALL have port imem_addr  out  32  instruction memory address; synchronous read, data on imem_rdata next cycle.
REQ-008 SHALL have port imem_rdata  in  32  instruction memory read data.
REQ-009 SHALL have port instr  out  32  instruction to decode; 32'h0 when instr_valid=0.
REQ-010 SHALL have port instr_valid  out  1  instr is live.
REQ-011 SHALL have ports pc_out, pc_plus4  out  32 each  PC of instr and PC+4 (jal link value).
REQ-012 SHALL have port halt  out  1  halt instruction retired.

Function
REQ-013 SHALL keep fpc (fetch PC, drives imem_addr) and dpc (PC of instr); pc_out=dpc and pc_plus4=dpc+4, mod 2^32.
REQ-014 SHALL implement states BOOT, RUN, STALL, FLUSH and HALT.
REQ-015 BOOT: instr_valid=0; fpc<=fpc+4; dpc<=fpc; next state RUN.
REQ-016 RUN with stall=0: instr=imem_rdata, valid=1; redirect taken -> fpc<=target, dpc<=fpc, state FLUSH; otherwise fpc<=fpc+4, dpc<=fpc.
REQ-017 RUN with stall=1: capture imem_rdata into a hold register, freeze fpc and dpc, state STALL; no redirect is evaluated.
REQ-018 STALL: instr=hold, valid=1, fpc and dpc frozen; when stall falls, redirect is evaluated and the advance happens exactly as in RUN, using the held instr.
REQ-019 FLUSH: instr_valid=0, which squashes the sequential word; fpc<=fpc+4, dpc<=fpc; state RUN; stall is ignored.
REQ-020 Redirect priority SHALL be jump_reg (target rs_val) > jump (target {pc_plus4[31:28], instr[25:0], 2'b00}) > any taken branch (target pc_plus4 + (sign-extended instr[15:0] << 2)).
REQ-021 Branch conditions SHALL be: branch rs==rt; branch_ne rs!=rt; branch_gt rs>rt signed; branch_gte rs>=rt signed; branch_lt rs<rt signed; branch_lte rs<=rt signed; branch_gt_u rs>rt unsigned; branch_lte_u rs<=rt unsigned.
REQ-022 A valid instr with opcode 6'h3F SHALL set halt=1 and move to HALT, with no fetch advance.
REQ-023 HALT: instr_valid=0, fpc and dpc frozen, halt=1 until rst.
REQ-024 A redirect SHALL cost exactly one bubble cycle; a non-redirecting instr SHALL cost zero.
REQ-025 Control inputs SHALL be ignored whenever instr_valid=0.

Reset
REQ-026 rst=1 SHALL force fpc=RESET_PC, dpc=RESET_PC, hold=0, state BOOT, instr_valid=0, instr=0 and halt=0 on the next edge, from any state including STALL and HALT.
REQ-027 While rst=1, imem_addr SHALL equal RESET_PC.

Structure
REQ-028 The shared package cpu_pkg SHALL hold the state enum, the HALT_OPCODE constant (6'h3F) and the RESET_PC default.
REQ-029 The comparator of REQ-021 SHALL be a combinational sub-module, branch_compare.

Verification
REQ-030 Reset then NOPs: imem_addr sequence 0,4,8,C; instr_valid first rises in the cycle after BOOT; pc_out 0,4,8.
REQ-031 beq at 0x10 with imm=3, rs=rt=5: next imem_addr 0x20; one invalid cycle; then pc_out=0x20. The same test with rs!=rt: no bubble, pc_out=0x14.
REQ-032 bgt with rs=0xFFFF_FFFF, rt=1: not taken. bgtu with the same operands: taken.
REQ-033 jr at 0x40 with rs_val=0x100 and jump=1 also set: target is 0x100, proving jr wins priority.
REQ-034 stall held 3 cycles on lw at 0x08: instr and pc_out stay 0x08; after release the next pc_out is 0x0C with the correct word and no duplicate.
REQ-035 halt word at 0x14: halt=1, instr_valid=0 and imem_addr frozen; rst=1 then returns to BOOT at RESET_PC.
